// File: rtl/seq_pkg.sv
// +------------------------------------------------------------------+
// | seq_pkg : shared state encoding and reference pattern            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int          PAT_LEN_1100111 = 7;
    localparam logic [6:0]  PATTERN_1100111 = 7'b1100111;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_bit_counter.sv
// +------------------------------------------------------------------+
// | seq_bit_counter : loadable down-counter with enable and zero flag|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module seq_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule : seq_bit_counter

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// +------------------------------------------------------------------+
// | seq_pattern_tx : repeats a fixed serial pattern MSB-first        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int                  PAT_LEN = 7,
    parameter logic [PAT_LEN-1:0]  PATTERN = PATTERN_1100111,
    parameter int                  GAP_LEN = 2,
    parameter int                  CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic             en,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic               bit_zero;
    logic [CNT_W-1:0]   rep_cnt;
    logic               rep_zero;

    logic               start_go;
    logic               send_bit;
    logic               pat_end;
    logic               rep_more;
    logic [CNT_W-1:0]   reps_eff;

    assign start_go = (state == IDLE) && start && !abort;
    assign send_bit = (state == SEND) && en && !abort;
    assign pat_end  = send_bit && bit_zero;
    assign rep_more = !rep_zero && (rep_cnt != CNT_W'(1));
    assign reps_eff = (reps == '0) ? CNT_W'(1) : reps;

    seq_bit_counter #(.WIDTH(IDX_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_go || (pat_end && rep_more)),
        .load_val (IDX_LAST),
        .dec      (send_bit && !bit_zero),
        .count    (bit_idx),
        .zero     (bit_zero)
    );

    seq_bit_counter #(.WIDTH(CNT_W)) u_rep_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_go),
        .load_val (reps_eff),
        .dec      (pat_end && rep_more),
        .count    (rep_cnt),
        .zero     (rep_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    done <= 1'b0;
                    if (en) begin
                        out       <= PATTERN[bit_idx];
                        out_valid <= 1'b1;
                        if (bit_zero) begin
                            if (!rep_more) begin
                                state <= FIN;
                            end else if (GAP_LEN > 0) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end
                        end
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                GAP: begin
                    done <= 1'b0;
                    if (en) begin
                        out       <= 1'b0;
                        out_valid <= 1'b1;
                        if (gap_cnt == GAP_END) begin
                            gap_cnt <= '0;
                            state   <= SEND;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                FIN: begin
                    // Completion step ignores en so done follows the last bit directly.
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : seq_pattern_tx

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// +------------------------------------------------------------------+
// | tb_seq_pattern_tx : randomized bench with a bit-stream model     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_seq_pattern_tx;

    localparam int PAT_LEN = 7;
    localparam int GAP_LEN = 2;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] reps = '0;
    logic             en = 1'b0;
    logic             abort = 1'b0;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    logic [PAT_LEN-1:0] pat_ref = 7'b1100111;

    seq_pattern_tx #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (7'b1100111),
        .GAP_LEN (GAP_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .reps      (reps),
        .en        (en),
        .abort     (abort),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_en(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected stream is built from the rules: R copies of the pattern, GAP_LEN zeros between.
    task automatic run_xfer(input int r, input int en_mode, input int ign_at,
                            input int abort_at, input bit fin_start);
        logic q[$];
        int   nr;
        int   emitted;
        int   cyc;
        logic last_out;
        logic b;
        nr = (r == 0) ? 1 : r;
        for (int k = 0; k < nr; k++) begin
            for (int j = PAT_LEN - 1; j >= 0; j--) q.push_back(pat_ref[j]);
            if (k < nr - 1) for (int g = 0; g < GAP_LEN; g++) q.push_back(1'b0);
        end
        emitted  = 0;
        cyc      = 0;
        last_out = 1'b0;

        start = 1'b1;
        reps  = CNT_W'(r);
        en    = pick_en(en_mode, cyc);
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid", out_valid, 0);
        check("start_done", done, 0);

        while (q.size() > 0) begin
            cyc++;
            en = pick_en(en_mode, cyc);
            if (abort_at >= 0 && emitted == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_out", out, 0);
                en = 1'b1;
                tick();
                check("abort_no_done", done, 0);
                check("abort_idle_busy", busy, 0);
                return;
            end
            if (ign_at >= 0 && emitted == ign_at) begin
                start = 1'b1;
                reps  = CNT_W'($urandom_range(0, 15));
            end
            tick();
            start = 1'b0;
            if (en) begin
                b = q.pop_front();
                check("bit_valid", out_valid, 1);
                check("bit_value", out, b);
                check("bit_busy", busy, 1);
                last_out = b;
                emitted++;
            end else begin
                check("stall_valid", out_valid, 0);
                check("stall_hold", out, last_out);
                check("stall_busy", busy, 1);
                check("stall_done", done, 0);
            end
        end

        en    = logic'($urandom_range(0, 1));
        start = fin_start;
        reps  = CNT_W'(1);
        tick();
        start = 1'b0;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", out_valid, 0);
        check("end_out", out, 0);
        if (fin_start) begin
            tick();
            check("fin_start_ignored", busy, 0);
            check("done_single", done, 0);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_busy", busy, 0);
        tick();
        tick();
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        run_xfer(1, 0, -1, -1, 1'b0);   // single shot
        run_xfer(3, 0, -1, -1, 1'b0);   // repeat with gaps, back-to-back start after done
        run_xfer(1, 1, -1, -1, 1'b0);   // stalled enable
        run_xfer(0, 0, 3, -1, 1'b0);    // zero reps, ignored start at bit 4
        run_xfer(1, 0, -1, 2, 1'b0);    // abort at third bit
        run_xfer(1, 0, -1, -1, 1'b1);   // full send after abort, start during FIN
        for (int t = 0; t < 6; t++) begin
            run_xfer(int'($urandom_range(0, 4)), 2, -1, -1, 1'b0);
        end

        // Asynchronous reset in the middle of a gap.
        start = 1'b1;
        reps  = CNT_W'(2);
        en    = 1'b1;
        tick();
        start = 1'b0;
        repeat (PAT_LEN + 1) tick();
        check("gap_bit_valid", out_valid, 1);
        check("gap_bit_out", out, 0);
        check("gap_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_valid", out_valid, 0);
            check("post_rst_done", done, 0);
        end
        run_xfer(2, 0, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_pattern_tx

`default_nettype wire
